instr_decode_pipe: RTL and testbench
====================================

# instr_decode_pipe

Registered, flow-controlled instruction decoder for the MIPS core's decode stage. It takes a full 32-bit instruction word and produces a one-hot operation vector. R-type instructions (opcode 0) are decoded on the funct field; all other instructions are decoded on the opcode field, so the two encodings never alias. The output is buffered through a 2-entry skid buffer with valid/ready handshakes on both sides, and the block flags and counts illegal encodings.

## Interface
- NUM_OPS, 36, width of the one-hot vector; must be ≥ 36; bits 36 and above are always 0.
- CNT_W, 16, width of the saturating illegal-instruction counter.
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- flush  in  1  synchronous pipeline clear.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  block can accept a word.
- in_instr  in  32  instruction word.
- out_valid  out  1  decoded entry valid.
- out_ready  in  1  downstream accepts.
- out_op  out  NUM_OPS  one-hot operation.
- out_illegal  out  1  no mapping matched; out_op is all-zero.
- out_nop  out  1  in_instr was 32'h0 (also decodes as SLL).
- out_instr  out  32  pass-through of the accepted word.
- illegal_cnt  out  CNT_W  count of illegal entries delivered.

## Operation
- Fields: opcode = instr[31:26], funct = instr[5:0].
- opcode == 0, decode funct to the one-hot bit index:
  - SLL 000000→0, SRL 000010→1, SRA 000011→2, SLLV 000100→3, SRLV 000110→4, JR 001000→5
  - SYSCALL 001100→6, MULT 011000→7, DIV 011010→8, ADD 100000→9, ADDU 100001→10, SUB 100010→11
  - SUBU 100011→12, AND 100100→13, OR 100101→14, XOR 100110→15, NOR 100111→16, SLT 101010→17
- opcode ≠ 0, decode opcode to the one-hot bit index:
  - BGEZ 000001→18, J 000010→19, JAL 000011→20, BEQ 000100→21, BNE 000101→22, BLEZ 000110→23
  - BGTZ 000111→24, ADDI 001000→25, ADDIU 001001→26, SLTI 001010→27, ANDI 001100→28, ORI 001101→29
  - XORI 001110→30, LUI 001111→31, LB 100000→32, LW 100011→33, SB 101000→34, SW 101011→35
- Any other opcode or funct: out_op = 0 and out_illegal = 1.
- Exactly one out_op bit is set, or out_illegal is set; never both, never neither, when out_valid = 1.
- Decode is combinational on in_instr. The result is captured with the word at acceptance, i.e. when in_valid & in_ready.

Skid buffer: an output register (O) and a skid register (S), each holding {op, illegal, nop, instr, valid}.
- in_ready = !S.valid (registered).
- Accept while O is empty or draining (!O.valid | out_ready): the new word goes to O, or S moves to O and the new word goes to S.
- Accept while O is stalled (O.valid & !out_ready): the new word goes to S.
- O drains on out_valid & out_ready. If S is valid, S moves to O and S empties.
- Ordering is strictly FIFO.
- Flush: O.valid and S.valid clear. A word offered in the flush cycle is discarded. illegal_cnt is unaffected.
- illegal_cnt increments on each output handshake with out_illegal = 1. It saturates at 2^CNT_W − 1.

## Timing
- Reset (async assert, sync use after release): out_valid = 0, in_ready = 1, out_op = 0, out_illegal = 0, out_nop = 0, out_instr = 0, illegal_cnt = 0.
- Latency: 1 cycle. A word accepted at edge N appears on out_* after edge N when the buffer was empty.
- Throughput: 1 word per cycle with out_ready held high.
- in_ready falls the cycle after S fills, and rises the cycle after S drains.
- At most 2 words are held. No word is lost or duplicated under any out_ready pattern.
- Simultaneous accept and drain with S full cannot occur, because in_ready = 0.
- Output fields are held stable while out_valid & !out_ready.
- Reset mid-transfer: all held entries are dropped immediately.
- Flush asserted together with out_ready: no handshake counts, and illegal_cnt does not change.

## Test plan
- 0x012A4020 (ADD), out_ready = 1: out_op = 1<<9 one cycle later, illegal = 0. 0x8D090004 (LW): bit 33.
- 0x00000000: bit 0 and out_nop = 1. 0x00000008 (JR): bit 5, and no aliasing to ADDI (bit 25). 0x21080001 (ADDI): bit 25.
- 0xFC000000 and 0x0000003F, each delivered twice: out_op = 0, out_illegal = 1, illegal_cnt = 4. With CNT_W = 2 and 5 illegals: cnt stays 3.
- out_ready = 0, stream 3 words: in_ready drops after 2 accepts. Release out_ready: words emerge in order, 1/cycle, and outputs hold stable while stalled.
- Random in_valid/out_ready over 10k words: scoreboard matches the decode table and the order.
- With 2 words held, assert flush: out_valid = 0 and in_ready = 1 next cycle, illegal_cnt unchanged. Assert rst_n = 0 mid-stream: all outputs go to reset values asynchronously.

Source files
------------

// File: rtl/instr_decode_pipe_if.sv
// Handshake bundle between the instruction fetch side and the decode consumer.
// master drives the upstream word and the downstream ready; slave is the decoder.
interface instr_decode_pipe_if #(
    parameter int NUM_OPS = 36
);
    logic               in_valid;
    logic               in_ready;
    logic [31:0]        in_instr;
    logic               out_valid;
    logic               out_ready;
    logic [NUM_OPS-1:0] out_op;
    logic               out_illegal;
    logic               out_nop;
    logic [31:0]        out_instr;

    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_op, out_illegal, out_nop, out_instr
    );

    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_op, out_illegal, out_nop, out_instr
    );
endinterface

// File: rtl/instr_decode_pipe.sv
// MIPS decode stage: one-hot operation decode of a 32-bit word, buffered through a
// 2-entry skid buffer, with a saturating count of delivered illegal encodings.
module instr_decode_pipe #(
    parameter int NUM_OPS = 36,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    instr_decode_pipe_if.slave bus,
    output logic [CNT_W-1:0]   illegal_cnt
);
    typedef struct packed {
        logic [NUM_OPS-1:0] op;
        logic               illegal;
        logic               nop;
        logic [31:0]        instr;
    } entry_t;

    entry_t     o_q, s_q, dec;
    logic       o_valid, s_valid;
    logic [5:0] opcode, funct, dec_idx;
    logic       dec_hit, accept, o_load, drain;

    assign opcode = bus.in_instr[31:26];
    assign funct  = bus.in_instr[5:0];

    // R-type keys on funct, everything else on opcode, so the two index ranges never alias
    always_comb begin
        dec_hit = 1'b1;
        dec_idx = 6'd0;
        if (opcode == 6'd0) begin
            case (funct)
                6'b000000: dec_idx = 6'd0;
                6'b000010: dec_idx = 6'd1;
                6'b000011: dec_idx = 6'd2;
                6'b000100: dec_idx = 6'd3;
                6'b000110: dec_idx = 6'd4;
                6'b001000: dec_idx = 6'd5;
                6'b001100: dec_idx = 6'd6;
                6'b011000: dec_idx = 6'd7;
                6'b011010: dec_idx = 6'd8;
                6'b100000: dec_idx = 6'd9;
                6'b100001: dec_idx = 6'd10;
                6'b100010: dec_idx = 6'd11;
                6'b100011: dec_idx = 6'd12;
                6'b100100: dec_idx = 6'd13;
                6'b100101: dec_idx = 6'd14;
                6'b100110: dec_idx = 6'd15;
                6'b100111: dec_idx = 6'd16;
                6'b101010: dec_idx = 6'd17;
                default:   dec_hit = 1'b0;
            endcase
        end else begin
            case (opcode)
                6'b000001: dec_idx = 6'd18;
                6'b000010: dec_idx = 6'd19;
                6'b000011: dec_idx = 6'd20;
                6'b000100: dec_idx = 6'd21;
                6'b000101: dec_idx = 6'd22;
                6'b000110: dec_idx = 6'd23;
                6'b000111: dec_idx = 6'd24;
                6'b001000: dec_idx = 6'd25;
                6'b001001: dec_idx = 6'd26;
                6'b001010: dec_idx = 6'd27;
                6'b001100: dec_idx = 6'd28;
                6'b001101: dec_idx = 6'd29;
                6'b001110: dec_idx = 6'd30;
                6'b001111: dec_idx = 6'd31;
                6'b100000: dec_idx = 6'd32;
                6'b100011: dec_idx = 6'd33;
                6'b101000: dec_idx = 6'd34;
                6'b101011: dec_idx = 6'd35;
                default:   dec_hit = 1'b0;
            endcase
        end
    end

    always_comb begin
        dec         = '0;
        dec.op      = dec_hit ? (NUM_OPS'(1) << dec_idx) : '0;
        dec.illegal = !dec_hit;
        dec.nop     = (bus.in_instr == 32'h0);
        dec.instr   = bus.in_instr;
    end

    assign accept = bus.in_valid && !s_valid;
    assign o_load = !o_valid || bus.out_ready;
    assign drain  = o_valid && bus.out_ready && !flush;

    // S only ever fills while O is stalled, so S valid implies O valid and in_ready low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_q     <= '0;
            s_q     <= '0;
            o_valid <= 1'b0;
            s_valid <= 1'b0;
        end else if (flush) begin
            o_valid <= 1'b0;
            s_valid <= 1'b0;
        end else if (o_load) begin
            if (s_valid) begin
                o_q     <= s_q;
                o_valid <= 1'b1;
                s_valid <= 1'b0;
            end else begin
                o_valid <= accept;
                if (accept) o_q <= dec;
            end
        end else if (accept) begin
            s_q     <= dec;
            s_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_cnt <= '0;
        end else if (drain && o_q.illegal && (illegal_cnt != {CNT_W{1'b1}})) begin
            illegal_cnt <= illegal_cnt + 1'b1;
        end
    end

    assign bus.in_ready    = !s_valid;
    assign bus.out_valid   = o_valid;
    assign bus.out_op      = o_q.op;
    assign bus.out_illegal = o_q.illegal;
    assign bus.out_nop     = o_q.nop;
    assign bus.out_instr   = o_q.instr;
endmodule

// File: tb/tb_instr_decode_pipe.sv
// Bench for instr_decode_pipe: directed decode table, stall/flush/reset sequences,
// and a randomized stream scored against a table-lookup decode model and a FIFO.
module tb_instr_decode_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic flush2 = 1'b0;
    logic [15:0] illegal_cnt;
    logic [1:0]  illegal_cnt2;

    int vectors = 0;
    int miscompares = 0;

    instr_decode_pipe_if #(.NUM_OPS(36)) bus ();
    instr_decode_pipe_if #(.NUM_OPS(36)) bus2 ();

    instr_decode_pipe #(.NUM_OPS(36), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus), .illegal_cnt(illegal_cnt)
    );

    instr_decode_pipe #(.NUM_OPS(36), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .flush(flush2), .bus(bus2), .illegal_cnt(illegal_cnt2)
    );

    always #5 clk = ~clk;

    logic [5:0] r_funct [18] = '{6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000110, 6'b001000,
                                 6'b001100, 6'b011000, 6'b011010, 6'b100000, 6'b100001, 6'b100010,
                                 6'b100011, 6'b100100, 6'b100101, 6'b100110, 6'b100111, 6'b101010};
    logic [5:0] i_opc [18]   = '{6'b000001, 6'b000010, 6'b000011, 6'b000100, 6'b000101, 6'b000110,
                                 6'b000111, 6'b001000, 6'b001001, 6'b001010, 6'b001100, 6'b001101,
                                 6'b001110, 6'b001111, 6'b100000, 6'b100011, 6'b101000, 6'b101011};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void ref_dec(input logic [31:0] w, output logic [63:0] op, output bit ill);
        op  = 64'd0;
        ill = 1'b1;
        for (int i = 0; i < 18; i++) begin
            if (w[31:26] == 6'd0 && w[5:0] == r_funct[i]) begin
                op  = 64'd1 << i;
                ill = 1'b0;
            end
            if (w[31:26] != 6'd0 && w[31:26] == i_opc[i]) begin
                op  = 64'd1 << (18 + i);
                ill = 1'b0;
            end
        end
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] r;
        r = $urandom();
        case ($urandom_range(0, 2))
            0: begin
                r[31:26] = 6'd0;
                r[5:0]   = r_funct[$urandom_range(0, 17)];
            end
            1: r[31:26] = i_opc[$urandom_range(0, 17)];
            default: ;
        endcase
        if ($urandom_range(0, 20) == 0) r = 32'h0;
        return r;
    endfunction

    typedef struct {
        logic [31:0] instr;
        int          idx;
        bit          ill;
        bit          nop;
    } vec_t;

    vec_t vt [9];

    task automatic check_reset_values(input string tag);
        check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        check({tag, "_out_op"}, 64'(bus.out_op), 64'd0);
        check({tag, "_out_illegal"}, 64'(bus.out_illegal), 64'd0);
        check({tag, "_out_nop"}, 64'(bus.out_nop), 64'd0);
        check({tag, "_out_instr"}, 64'(bus.out_instr), 64'd0);
        check({tag, "_cnt"}, 64'(illegal_cnt), 64'd0);
        check({tag, "_cnt2"}, 64'(illegal_cnt2), 64'd0);
    endtask

    initial begin
        logic [31:0] q[$];
        logic [31:0] front;
        logic [63:0] exp_op;
        bit          exp_ill;
        int          words;
        int          cyc;
        int          ill_model;

        vt[0] = '{32'h012A4020, 9, 1'b0, 1'b0};
        vt[1] = '{32'h8D090004, 33, 1'b0, 1'b0};
        vt[2] = '{32'h00000000, 0, 1'b0, 1'b1};
        vt[3] = '{32'h00000008, 5, 1'b0, 1'b0};
        vt[4] = '{32'h21080001, 25, 1'b0, 1'b0};
        vt[5] = '{32'hFC000000, -1, 1'b1, 1'b0};
        vt[6] = '{32'h0000003F, -1, 1'b1, 1'b0};
        vt[7] = '{32'hFC000000, -1, 1'b1, 1'b0};
        vt[8] = '{32'h0000003F, -1, 1'b1, 1'b0};

        bus.in_valid   = 1'b0;
        bus.in_instr   = 32'h0;
        bus.out_ready  = 1'b0;
        bus2.in_valid  = 1'b0;
        bus2.in_instr  = 32'h0;
        bus2.out_ready = 1'b0;

        #12;
        check_reset_values("reset");
        rst_n = 1'b1;
        tick();

        // directed decode table, one word at a time with out_ready high
        for (int i = 0; i < 9; i++) begin
            bus.out_ready = 1'b1;
            bus.in_valid  = 1'b1;
            bus.in_instr  = vt[i].instr;
            tick();
            bus.in_valid = 1'b0;
            check("tbl_out_valid", 64'(bus.out_valid), 64'd1);
            check("tbl_out_op", 64'(bus.out_op), vt[i].ill ? 64'd0 : (64'd1 << vt[i].idx));
            check("tbl_out_illegal", 64'(bus.out_illegal), 64'(vt[i].ill));
            check("tbl_out_nop", 64'(bus.out_nop), 64'(vt[i].nop));
            check("tbl_out_instr", 64'(bus.out_instr), 64'(vt[i].instr));
            tick();
            check("tbl_drained", 64'(bus.out_valid), 64'd0);
        end
        check("tbl_illegal_cnt", 64'(illegal_cnt), 64'd4);

        // saturation on the 2-bit counter instance
        bus2.out_ready = 1'b1;
        bus2.in_valid  = 1'b1;
        bus2.in_instr  = 32'hFC000000;
        for (int i = 0; i < 5; i++) tick();
        bus2.in_valid = 1'b0;
        tick();
        tick();
        check("sat_cnt2", 64'(illegal_cnt2), 64'd3);

        // stall: three words offered, only two fit, then release in order
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_instr  = 32'h012A4020;
        tick();
        check("stall_in_ready_1", 64'(bus.in_ready), 64'd1);
        check("stall_out_instr_1", 64'(bus.out_instr), 64'h012A4020);
        bus.in_instr = 32'h8D090004;
        tick();
        check("stall_in_ready_2", 64'(bus.in_ready), 64'd0);
        check("stall_out_instr_2", 64'(bus.out_instr), 64'h012A4020);
        bus.in_instr = 32'h21080001;
        tick();
        check("stall_in_ready_3", 64'(bus.in_ready), 64'd0);
        check("stall_hold_instr", 64'(bus.out_instr), 64'h012A4020);
        check("stall_hold_op", 64'(bus.out_op), 64'd1 << 9);
        bus.out_ready = 1'b1;
        tick();
        check("release_1_instr", 64'(bus.out_instr), 64'h8D090004);
        check("release_1_op", 64'(bus.out_op), 64'd1 << 33);
        check("release_1_in_ready", 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
        check("release_2_valid", 64'(bus.out_valid), 64'd1);
        check("release_2_instr", 64'(bus.out_instr), 64'h21080001);
        tick();
        check("release_empty", 64'(bus.out_valid), 64'd0);

        // flush with two illegal words held, out_ready high and a new word offered
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_instr  = 32'hFC000000;
        tick();
        bus.in_instr = 32'h0000003F;
        tick();
        check("flush_pre_in_ready", 64'(bus.in_ready), 64'd0);
        check("flush_pre_out_valid", 64'(bus.out_valid), 64'd1);
        flush         = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_instr  = 32'h012A4020;
        tick();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_out_valid", 64'(bus.out_valid), 64'd0);
        check("flush_in_ready", 64'(bus.in_ready), 64'd1);
        check("flush_cnt", 64'(illegal_cnt), 64'd4);
        tick();
        check("flush_discard", 64'(bus.out_valid), 64'd0);

        // asynchronous reset with two words held
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_instr  = 32'h8D090004;
        tick();
        bus.in_instr = 32'hFC000000;
        tick();
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // randomized stream against the FIFO scoreboard
        words     = 0;
        cyc       = 0;
        ill_model = 0;
        while ((words < 10000 || q.size() != 0) && cyc < 60000) begin
            if (words < 10000) begin
                bus.in_valid  = ($urandom_range(0, 3) != 0);
                bus.out_ready = ($urandom_range(0, 9) < 6);
            end else begin
                bus.in_valid  = 1'b0;
                bus.out_ready = 1'b1;
            end
            bus.in_instr = gen_instr();
            @(negedge clk);
            check("rnd_in_ready", 64'(bus.in_ready), 64'(q.size() < 2));
            check("rnd_out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
            if (bus.out_valid && q.size() != 0) begin
                front = q[0];
                ref_dec(front, exp_op, exp_ill);
                check("rnd_out_instr", 64'(bus.out_instr), 64'(front));
                check("rnd_out_op", 64'(bus.out_op), exp_op);
                check("rnd_out_illegal", 64'(bus.out_illegal), 64'(exp_ill));
                check("rnd_out_nop", 64'(bus.out_nop), 64'(front == 32'h0));
                if (bus.out_ready) begin
                    void'(q.pop_front());
                    if (exp_ill) ill_model++;
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(bus.in_instr);
                words++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.in_valid = 1'b0;
        check("rnd_words_done", 64'(words), 64'd10000);
        check("rnd_queue_empty", 64'(q.size()), 64'd0);
        check("rnd_illegal_cnt", 64'(illegal_cnt), 64'(ill_model));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
